// File: rtl/uart_rx_fifo.sv
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic [CNT_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          rx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 meta_q, meta_d;
  logic                 rxs_q, rxs_d;
  logic                 rxs_prev_q, rxs_prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     div_q, div_d;
  logic [1:0]           par_q, par_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [WW-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic [CNT_W-1:0]     div_in;
  logic                 fall;
  logic                 tick;
  logic                 par_en;
  logic                 par_odd;
  logic                 ferr_now;
  logic                 push;
  logic [WW-1:0]        push_word;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 wr_en;

  assign div_in  = (baud_div < CNT_W'(4)) ? CNT_W'(4) : baud_div;
  assign fall    = rxs_prev_q & ~rxs_q;
  // A load of N expires exactly N clocks later (expiry on reaching 1).
  assign tick    = (cnt_q == CNT_W'(1));
  assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);
  assign par_odd = (par_q == 2'b10);

  always_comb begin
    meta_d     = rxd;
    rxs_d      = meta_q;
    rxs_prev_d = rxs_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    par_d      = par_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ferr_now   = ferr_q;
    push       = 1'b0;
    push_word  = '0;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = div_in >> 1;
          div_d   = div_in;
          par_d   = parity_mode;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = div_q;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = div_q;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = div_q;
          perr_d  = ((^shift_q) ^ rxs_q) != par_odd;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d    = div_q;
          ferr_now = ferr_q | ~rxs_q;
          ferr_d   = ferr_now;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d     = '0;
            push      = 1'b1;
            push_word = {ferr_now, perr_q, shift_q};
            state_d   = rxs_q ? S_IDLE : S_BREAK;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = ~empty & rx_ready;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push & full & ~pop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      par_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      par_q      <= par_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data       = mem_q[rd_ptr_q][DATA_BITS-1:0];
  assign rx_parity_err = mem_q[rd_ptr_q][DATA_BITS];
  assign rx_frame_err  = mem_q[rd_ptr_q][DATA_BITS+1];
  assign rx_valid      = ~empty;
  assign fifo_count    = count_q;
  assign overrun       = overrun_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic        clk;
  logic        reset;
  logic        rxd;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic [7:0]  rx_data;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        overrun_clr;
  logic        rx_busy;

  int vectors;
  int miscompares;
  int bit_clks;
  int lat0;
  int lat;
  logic vb;
  logic va;

  uart_rx_fifo #(
    .DATA_BITS (8),
    .STOP_BITS (1),
    .FIFO_DEPTH(4),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .baud_div     (baud_div),
    .parity_mode  (parity_mode),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .fifo_count   (fifo_count),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; rxd is left at the stop level. busy_fall is the edge
  // index (counted from the start bit) at which rx_busy dropped, -1 if never.
  task automatic send_frame(input logic [7:0] data, input bit with_par, input logic par_bit,
                            input logic stop_val, input int pop_edge,
                            output int busy_fall, output logic v_before, output logic v_at);
    logic [10:0] bits;
    int   n;
    int   cyc;
    logic was_busy;
    logic prev_v;
    bits      = '0;
    bits[8:1] = data;
    n         = 9;
    if (with_par) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n]   = stop_val;
    n++;
    cyc       = 0;
    busy_fall = -1;
    was_busy  = 1'b0;
    v_before  = 1'b0;
    v_at      = 1'b0;
    prev_v    = rx_valid;
    for (int b = 0; b < n; b++) begin
      rxd = bits[b];
      for (int k = 0; k < bit_clks; k++) begin
        rx_ready = (cyc + 1 == pop_edge);
        @(posedge clk);
        #1;
        cyc++;
        if (rx_busy) begin
          was_busy = 1'b1;
        end else if (was_busy && busy_fall < 0) begin
          busy_fall = cyc;
          v_before  = prev_v;
          v_at      = rx_valid;
        end
        prev_v = rx_valid;
      end
    end
    rx_ready = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    chk({tag, "_valid"}, 32'(rx_valid), 1);
    chk({tag, "_data"}, 32'(rx_data), 32'(d));
    chk({tag, "_perr"}, 32'(rx_parity_err), 32'(pe));
    chk({tag, "_ferr"}, 32'(rx_frame_err), 32'(fe));
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bit_clks    = 16;
    lat0        = 155;
    reset       = 1'b1;
    rxd         = 1'b1;
    baud_div    = 16'd16;
    parity_mode = 2'b00;
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_perr", 32'(rx_parity_err), 0);
    chk("rst_ferr", 32'(rx_frame_err), 0);
    idle(4);

    // 8N1 frames 0x55 and 0xA3, not popped
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0, lat, vb, va);
    chk("lat_window", 32'(lat >= 145 && lat <= 160), 1);
    chk("valid_before_push", 32'(vb), 0);
    chk("valid_on_push", 32'(va), 1);
    if (lat > 0) lat0 = lat;
    idle(4);
    send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 0, lat, vb, va);
    idle(4);
    chk("two_count", 32'(fifo_count), 2);
    pop_chk("w55", 8'h55, 1'b0, 1'b0);
    pop_chk("wA3", 8'hA3, 1'b0, 1'b0);
    chk("empty_count", 32'(fifo_count), 0);
    chk("empty_valid", 32'(rx_valid), 0);

    // rx_ready while empty has no effect
    rx_ready = 1'b1;
    idle(3);
    rx_ready = 1'b0;
    chk("empty_pop_count", 32'(fifo_count), 0);

    // Even parity: wrong then right parity bit; odd parity
    parity_mode = 2'b01;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, lat, vb, va);
    idle(4);
    pop_chk("even_bad", 8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0, lat, vb, va);
    idle(4);
    pop_chk("even_good", 8'h07, 1'b0, 1'b0);
    parity_mode = 2'b10;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, lat, vb, va);
    idle(4);
    pop_chk("odd_good", 8'h07, 1'b0, 1'b0);
    parity_mode = 2'b00;

    // Divisor below 4 runs at 4 clocks per bit
    baud_div = 16'd2;
    bit_clks = 4;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 0, lat, vb, va);
    idle(8);
    pop_chk("clamp", 8'h96, 1'b0, 1'b0);
    baud_div = 16'd16;
    bit_clks = 16;
    idle(4);

    // Start glitch of 3 clocks
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd = 1'b1;
    idle(1);
    chk("glitch_busy", 32'(rx_busy), 1);
    idle(30);
    chk("glitch_idle", 32'(rx_busy), 0);
    chk("glitch_count", 32'(fifo_count), 0);

    // Framing error followed by a 40 bit-time break
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, lat, vb, va);
    idle(40 * 16);
    chk("break_count", 32'(fifo_count), 1);
    chk("break_busy", 32'(rx_busy), 1);
    chk("break_data", 32'(rx_data), 'h3C);
    chk("break_ferr", 32'(rx_frame_err), 1);
    chk("break_perr", 32'(rx_parity_err), 0);
    rxd = 1'b1;
    idle(10);
    chk("break_exit", 32'(rx_busy), 0);
    chk("break_count2", 32'(fifo_count), 1);

    // Reset in DATA with one word buffered
    rxd = 1'b0;
    idle(16);
    rxd = 1'b1;
    idle(20);
    chk("mid_busy", 32'(rx_busy), 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mrst_valid", 32'(rx_valid), 0);
    chk("mrst_count", 32'(fifo_count), 0);
    chk("mrst_busy", 32'(rx_busy), 0);
    chk("mrst_data", 32'(rx_data), 0);
    chk("mrst_ferr", 32'(rx_frame_err), 0);
    idle(20);
    chk("mrst_nopush", 32'(fifo_count), 0);
    send_frame(8'hC5, 1'b0, 1'b0, 1'b1, 0, lat, vb, va);
    idle(4);
    chk("post_rst_count", 32'(fifo_count), 1);
    pop_chk("post_rst", 8'hC5, 1'b0, 1'b0);

    // Overrun: five words into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1, 0, lat, vb, va);
      idle(4);
    end
    chk("ovr_count", 32'(fifo_count), 4);
    chk("ovr_flag", 32'(overrun), 1);
    idle(10);
    chk("ovr_sticky", 32'(overrun), 1);
    pop_chk("ovr_01", 8'h01, 1'b0, 1'b0);
    pop_chk("ovr_02", 8'h02, 1'b0, 1'b0);
    pop_chk("ovr_03", 8'h03, 1'b0, 1'b0);
    pop_chk("ovr_04", 8'h04, 1'b0, 1'b0);
    chk("ovr_empty", 32'(fifo_count), 0);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 0);

    // Full FIFO with a pop on the same edge as the fifth push
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1, 0, lat, vb, va);
      idle(4);
    end
    chk("sim_full", 32'(fifo_count), 4);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, lat0, lat, vb, va);
    idle(4);
    chk("sim_lat", 32'(lat), 32'(lat0));
    chk("sim_count", 32'(fifo_count), 4);
    chk("sim_overrun", 32'(overrun), 0);
    pop_chk("sim_02", 8'h02, 1'b0, 1'b0);
    pop_chk("sim_03", 8'h03, 1'b0, 1'b0);
    pop_chk("sim_04", 8'h04, 1'b0, 1'b0);
    pop_chk("sim_05", 8'h05, 1'b0, 1'b0);
    chk("sim_empty", 32'(rx_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
